tx_chan_output_stage: RTL

TX_CHAN_OUTPUT_STAGE -- requirements
Module: tx_chan_output_stage

---
 rtl/tx_chan_output_stage_pkg.sv | 39 +++
 rtl/tx_strobe_div.sv | 63 ++++++
 rtl/tx_chan_output_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tx_chan_output_stage_pkg.sv
// ---------------------------------------------------------------------------
// tx_chan_output_stage_pkg
//
// Shared constants and types for the TX channel output stage.
//   MAX_CHAN    : largest supported number of transmit data channels
//   SAMPLE_W    : width of one I or Q sample
//   DEF_RATE_W  : default width of a per-channel strobe-rate field
//   DEF_CNT_W   : default width of a per-channel underrun counter
//   sample_t    : one I or Q sample
// ---------------------------------------------------------------------------
package tx_chan_output_stage_pkg;

   localparam int MAX_CHAN   = 4;
   localparam int SAMPLE_W   = 16;
   localparam int DEF_RATE_W = 8;
   localparam int DEF_CNT_W  = 16;

   typedef logic [SAMPLE_W-1:0] sample_t;

   // Next value of a saturating up-counter with a synchronous clear.
   // A clear that coincides with an event leaves the counter at 1, so the
   // event that arrived together with the clear is not lost.
   function automatic logic [31:0] sat_count_next(
      input logic [31:0] cur,
      input logic [31:0] max_val,
      input logic        event_in,
      input logic        clear_in
   );
      logic [31:0] nxt;
      nxt = cur;
      if (clear_in) begin
         nxt = event_in ? 32'd1 : 32'd0;
      end else if (event_in && (cur != max_val)) begin
         nxt = cur + 32'd1;
      end
      return nxt;
   endfunction

endpackage : tx_chan_output_stage_pkg

// File: rtl/tx_strobe_div.sv
// ---------------------------------------------------------------------------
// tx_strobe_div
//
// Per-channel strobe divider. Produces one registered strobe pulse for every
// R qualifying base strobes, where R is the live value on 'rate'.
//
// Ports
//   txclk    in   clock, all state updates on its rising edge
//   reset    in   synchronous, active-high reset
//   txstrobe in   base sample strobe
//   rate     in   decimation R; R = 0 disables the channel
//   strobe   out  one-cycle pulse, registered (one cycle after the
//                 txstrobe that completes a period)
// ---------------------------------------------------------------------------
module tx_strobe_div #(
   parameter int RATE_W = 8
) (
   input  logic              txclk,
   input  logic              reset,
   input  logic              txstrobe,
   input  logic [RATE_W-1:0] rate,
   output logic              strobe
);

   localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

   logic [RATE_W-1:0] cnt_q;
   logic [RATE_W-1:0] cnt_d;
   logic              strobe_q;
   logic              strobe_d;

   // The terminal test is ">=" rather than "==": if rate is lowered while
   // the count is already past the new terminal value, the very next base
   // strobe ends the period instead of letting the count wrap through the
   // whole counter range.
   always_comb begin
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      if (rate == '0) begin
         cnt_d = '0;
      end else if (txstrobe) begin
         if (cnt_q >= (rate - RATE_ONE)) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
         end else begin
            cnt_d = cnt_q + RATE_ONE;
         end
      end
   end

   always_ff @(posedge txclk) begin
      if (reset) begin
         cnt_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
      end
   end

   assign strobe = strobe_q;

endmodule : tx_strobe_div

// File: rtl/tx_chan_output_stage.sv
// ---------------------------------------------------------------------------
// tx_chan_output_stage
//
// Output stage of the transmit channel path: per-channel strobe generation,
// sample gating/registering towards the TX chains, aggregate buffer flags
// and per-channel underrun status.
//
// Parameters
//   NUM_CHAN  number of data channels (1..MAX_CHAN)
//   RATE_W    width of each strobe-rate field
//   CNT_W     width of each underrun counter
//
// Ports
//   txclk            in   sole clock
//   reset            in   synchronous, active-high reset
//   txstrobe         in   base sample strobe
//   strobe_rate      in   per-channel decimation, field k at [k*RATE_W +: RATE_W]
//   chan_strobe      out  per-channel one-cycle sample strobes
//   chan_i_in/q_in   in   per-channel samples, field k at [k*16 +: 16]
//   chan_txempty     in   per-channel reader-empty flags
//   chan_underrun    in   per-channel underrun pulses
//   chan_have_space  in   buffer-space flags, bit NUM_CHAN is the command channel
//   clear_status     in   clears underrun sticky bits and counters
//   tx_i, tx_q       out  registered samples, zeroed for an empty channel
//   have_space       out  registered AND of all chan_have_space bits
//   tx_empty         out  registered AND of all chan_txempty bits
//   underrun_sticky  out  per-channel sticky underrun flags
//   underrun_count   out  per-channel saturating underrun counts
// ---------------------------------------------------------------------------
module tx_chan_output_stage
   import tx_chan_output_stage_pkg::*;
#(
   parameter int NUM_CHAN = 2,
   parameter int RATE_W   = DEF_RATE_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                         txclk,
   input  logic                         reset,
   input  logic                         txstrobe,
   input  logic [NUM_CHAN*RATE_W-1:0]   strobe_rate,
   output logic [NUM_CHAN-1:0]          chan_strobe,
   input  logic [NUM_CHAN*SAMPLE_W-1:0] chan_i_in,
   input  logic [NUM_CHAN*SAMPLE_W-1:0] chan_q_in,
   input  logic [NUM_CHAN-1:0]          chan_txempty,
   input  logic [NUM_CHAN-1:0]          chan_underrun,
   input  logic [NUM_CHAN:0]            chan_have_space,
   input  logic                         clear_status,
   output logic [NUM_CHAN*SAMPLE_W-1:0] tx_i,
   output logic [NUM_CHAN*SAMPLE_W-1:0] tx_q,
   output logic                         have_space,
   output logic                         tx_empty,
   output logic [NUM_CHAN-1:0]          underrun_sticky,
   output logic [NUM_CHAN*CNT_W-1:0]    underrun_count
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   // ------------------------------------------------------------------
   // Per-channel strobe dividers
   // ------------------------------------------------------------------
   for (genvar g = 0; g < NUM_CHAN; g++) begin : g_div
      tx_strobe_div #(
         .RATE_W (RATE_W)
      ) u_div (
         .txclk    (txclk),
         .reset    (reset),
         .txstrobe (txstrobe),
         .rate     (strobe_rate[g*RATE_W +: RATE_W]),
         .strobe   (chan_strobe[g])
      );
   end

   // ------------------------------------------------------------------
   // Sample gating and aggregate flags
   // ------------------------------------------------------------------
   logic [NUM_CHAN*SAMPLE_W-1:0] tx_i_q;
   logic [NUM_CHAN*SAMPLE_W-1:0] tx_i_d;
   logic [NUM_CHAN*SAMPLE_W-1:0] tx_q_q;
   logic [NUM_CHAN*SAMPLE_W-1:0] tx_q_d;
   logic                         have_space_q;
   logic                         have_space_d;
   logic                         tx_empty_q;
   logic                         tx_empty_d;

   // An empty reader presents stale data on its sample bus, so the sample
   // is replaced by zero for that cycle rather than forwarded.
   always_comb begin
      tx_i_d = '0;
      tx_q_d = '0;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (!chan_txempty[k]) begin
            tx_i_d[k*SAMPLE_W +: SAMPLE_W] = chan_i_in[k*SAMPLE_W +: SAMPLE_W];
            tx_q_d[k*SAMPLE_W +: SAMPLE_W] = chan_q_in[k*SAMPLE_W +: SAMPLE_W];
         end
      end
      have_space_d = &chan_have_space;
      tx_empty_d   = &chan_txempty;
   end

   // ------------------------------------------------------------------
   // Underrun status
   // ------------------------------------------------------------------
   logic [NUM_CHAN-1:0]       sticky_q;
   logic [NUM_CHAN-1:0]       sticky_d;
   logic [NUM_CHAN*CNT_W-1:0] ucnt_q;
   logic [NUM_CHAN*CNT_W-1:0] ucnt_d;

   // A pulse arriving together with clear_status wins over the clear, so an
   // underrun is never silently dropped by a concurrent status read/clear.
   always_comb begin
      sticky_d = sticky_q;
      ucnt_d   = ucnt_q;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (chan_underrun[k]) begin
            sticky_d[k] = 1'b1;
         end else if (clear_status) begin
            sticky_d[k] = 1'b0;
         end
         ucnt_d[k*CNT_W +: CNT_W] = CNT_W'(sat_count_next(
            32'(ucnt_q[k*CNT_W +: CNT_W]), CNT_MAX,
            chan_underrun[k], clear_status));
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge txclk) begin
      if (reset) begin
         tx_i_q       <= '0;
         tx_q_q       <= '0;
         have_space_q <= 1'b0;
         tx_empty_q   <= 1'b1;
         sticky_q     <= '0;
         ucnt_q       <= '0;
      end else begin
         tx_i_q       <= tx_i_d;
         tx_q_q       <= tx_q_d;
         have_space_q <= have_space_d;
         tx_empty_q   <= tx_empty_d;
         sticky_q     <= sticky_d;
         ucnt_q       <= ucnt_d;
      end
   end

   assign tx_i            = tx_i_q;
   assign tx_q            = tx_q_q;
   assign have_space      = have_space_q;
   assign tx_empty        = tx_empty_q;
   assign underrun_sticky = sticky_q;
   assign underrun_count  = ucnt_q;

endmodule : tx_chan_output_stage
